// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Central sequencer that turns the single-cycle RISC-V datapath into a
// multi-cycle machine. Each instruction walks FETCH -> DECODE -> EXEC and
// then, depending on its class, MEM and/or WB before returning to FETCH.
// The block raises the per-phase enables for PC, instruction register,
// register file, ALU and data memory. It also reports sticky faults for
// illegal opcodes and memory timeouts, and counts retired instructions.
//
// Parameters
//   MEM_WAIT_MAX : consecutive MEM cycles with memReady low before a timeout
//                  fault (1..255)
//   CNT_WIDTH    : width of the retired-instruction counter
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : synchronous, active-high
//   opcode[6:0]  : opcode from the instruction register (stable DECODE..retire)
//   aluZero      : ALU zero flag, meaningful in EXEC
//   memReady     : data-memory completion for the current access
//   pcWrite      : PC load enable
//   pcSrc        : 0 = PC+4, 1 = branch target
//   irWrite      : instruction register load enable
//   aluSrc       : 0 = readData2, 1 = immediate
//   aluOp[1:0]   : 00 add, 01 sub/compare, 10 funct-decoded
//   memRead      : data-memory read strobe
//   memWrite     : data-memory write strobe
//   memtoReg     : writeback source, 1 = memory, 0 = ALU
//   regWrite     : register file write enable
//   state[2:0]   : current state code (FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
//                  FAULT=7)
//   illegal      : sticky illegal-opcode fault
//   memTimeout   : sticky memory-timeout fault
//   instRetired  : retired-instruction count, wraps from all-ones to zero
//
// Data-memory handshake: while in MEM the read or write strobe is held high
// every cycle. The access completes in the first cycle that memReady is
// sampled high on a rising edge. memReady is ignored in every other state.
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 aluZero,
    input  logic                 memReady,
    output logic                 pcWrite,
    output logic                 pcSrc,
    output logic                 irWrite,
    output logic                 aluSrc,
    output logic [1:0]           aluOp,
    output logic                 memRead,
    output logic                 memWrite,
    output logic                 memtoReg,
    output logic                 regWrite,
    output logic [2:0]           state,
    output logic                 illegal,
    output logic                 memTimeout,
    output logic [CNT_WIDTH-1:0] instRetired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Last wait-counter value tolerated before the timeout fault.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     state_q;
    logic [7:0] wait_cnt;

    // Opcode class decode
    logic is_r;
    logic is_i;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_mem;
    logic supported;

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_mem    = is_load | is_store;
    assign supported = is_r | is_i | is_mem | is_branch;

    // An instruction retires on the edge leaving its last state: EXEC for a
    // branch, MEM for a completed store, WB for everything that writes back.
    logic retire_now;

    always_comb begin
        retire_now = 1'b0;
        case (state_q)
            S_EXEC:  retire_now = is_branch;
            S_MEM:   retire_now = is_store & memReady;
            S_WB:    retire_now = 1'b1;
            default: retire_now = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencer state, sticky faults, wait counter and retire counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            wait_cnt    <= '0;
            illegal     <= 1'b0;
            memTimeout  <= 1'b0;
            instRetired <= '0;
        end else begin
            if (retire_now) begin
                instRetired <= instRetired + CNT_WIDTH'(1);
            end

            case (state_q)
                S_FETCH: begin
                    state_q <= S_DECODE;
                end

                S_DECODE: begin
                    if (supported) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q <= S_FAULT;
                        illegal <= 1'b1;
                    end
                end

                S_EXEC: begin
                    if (is_branch) begin
                        state_q <= S_FETCH;
                    end else if (is_mem) begin
                        state_q  <= S_MEM;
                        wait_cnt <= '0;
                    end else if (is_r | is_i) begin
                        state_q <= S_WB;
                    end else begin
                        // Opcode changed under us after DECODE accepted it.
                        state_q <= S_FAULT;
                        illegal <= 1'b1;
                    end
                end

                S_MEM: begin
                    if (!is_mem) begin
                        state_q <= S_FAULT;
                        illegal <= 1'b1;
                    end else if (memReady) begin
                        state_q <= is_load ? S_WB : S_FETCH;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_q    <= S_FAULT;
                        memTimeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_WB: begin
                    state_q <= S_FETCH;
                end

                S_FAULT: begin
                    // Only reset leaves FAULT; both flags hold.
                    state_q <= S_FAULT;
                end

                default: begin
                    // Unused codes 5 and 6.
                    state_q <= S_FAULT;
                    illegal <= 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Per-phase strobes. They are combinational from state, opcode and
    // aluZero, and forced to zero while reset is high, so the datapath is
    // quiet even before the reset edge lands.
    // -------------------------------------------------------------------------
    always_comb begin
        pcWrite  = 1'b0;
        pcSrc    = 1'b0;
        irWrite  = 1'b0;
        aluSrc   = 1'b0;
        aluOp    = ALU_ADD;
        memRead  = 1'b0;
        memWrite = 1'b0;
        memtoReg = 1'b0;
        regWrite = 1'b0;

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    irWrite = 1'b1;
                end

                S_EXEC: begin
                    if (is_r) begin
                        aluSrc = 1'b0;
                        aluOp  = ALU_FUNCT;
                    end else if (is_i) begin
                        aluSrc = 1'b1;
                        aluOp  = ALU_FUNCT;
                    end else if (is_mem) begin
                        aluSrc = 1'b1;
                        aluOp  = ALU_ADD;
                    end else if (is_branch) begin
                        aluSrc  = 1'b0;
                        aluOp   = ALU_SUB;
                        pcWrite = 1'b1;
                        pcSrc   = aluZero;
                    end
                end

                S_MEM: begin
                    // Address computation stays on the ALU while the access is
                    // outstanding.
                    aluSrc   = 1'b1;
                    aluOp    = ALU_ADD;
                    memRead  = is_load;
                    memWrite = is_store;
                    // A store finishes here, so it also advances the PC.
                    pcWrite  = is_store & memReady;
                end

                S_WB: begin
                    regWrite = 1'b1;
                    memtoReg = is_load;
                    pcWrite  = 1'b1;
                end

                default: begin
                    // DECODE and FAULT drive no strobes.
                end
            endcase
        end
    end

    assign state = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Drives two copies of multicycle_control from the same inputs. The first
// copy uses the default 32-bit counter and the second a 4-bit counter, so
// counter wrap can be seen. A behavioural model plans each instruction as a
// list of phases with the inputs for each phase. From that list it builds
// the expected state/strobe word for every cycle in exp_q. A single negedge
// compare process checks both DUT copies against the current expectation.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int MEM_WAIT_MAX = 15;

    // Instruction classes used by the model
    localparam int C_R   = 0;
    localparam int C_I   = 1;
    localparam int C_LD  = 2;
    localparam int C_ST  = 3;
    localparam int C_BR  = 4;
    localparam int C_BAD = 5;

    // Phase numbers equal the documented state codes
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_X = 7;

    // ---------------------------------------------------------------- clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------- DUT I/O
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic        pc_write, pc_src, ir_write, alu_src, mem_read, mem_write;
    logic        memto_reg, reg_write, illegal, mem_timeout;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] inst_retired;

    logic        pc_write4, pc_src4, ir_write4, alu_src4, mem_read4, mem_write4;
    logic        memto_reg4, reg_write4, illegal4, mem_timeout4;
    logic [1:0]  alu_op4;
    logic [2:0]  state4;
    logic [3:0]  inst_retired4;

    multicycle_control #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .aluZero(alu_zero),
        .memReady(mem_ready), .pcWrite(pc_write), .pcSrc(pc_src),
        .irWrite(ir_write), .aluSrc(alu_src), .aluOp(alu_op),
        .memRead(mem_read), .memWrite(mem_write), .memtoReg(memto_reg),
        .regWrite(reg_write), .state(state), .illegal(illegal),
        .memTimeout(mem_timeout), .instRetired(inst_retired)
    );

    multicycle_control #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .aluZero(alu_zero),
        .memReady(mem_ready), .pcWrite(pc_write4), .pcSrc(pc_src4),
        .irWrite(ir_write4), .aluSrc(alu_src4), .aluOp(alu_op4),
        .memRead(mem_read4), .memWrite(mem_write4), .memtoReg(memto_reg4),
        .regWrite(reg_write4), .state(state4), .illegal(illegal4),
        .memTimeout(mem_timeout4), .instRetired(inst_retired4)
    );

    // ------------------------------------------------------------ counters
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // --------------------------------------------------------------- model
    int unsigned m_cnt = 0;   // retired instructions since reset
    logic        m_ill = 1'b0;
    logic        m_to  = 1'b0;

    // Current-cycle expectation consumed by the compare process
    logic        exp_on    = 1'b0;
    logic        exp_flags = 1'b0;
    logic [2:0]  exp_state = 3'd0;
    logic [9:0]  exp_strb  = 10'd0;
    logic        exp_ill   = 1'b0;
    logic        exp_to    = 1'b0;
    logic [31:0] exp_cnt   = 32'd0;

    function automatic int classify(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b1100011: return C_BR;
            default:    return C_BAD;
        endcase
    endfunction

    // Strobe word {pcWrite,pcSrc,irWrite,aluSrc,aluOp[1:0],memRead,memWrite,
    // memtoReg,regWrite} from the phase table of the controller description.
    function automatic logic [9:0] spec_outputs(input int ph, input int cls,
                                                input logic zero, input logic ready);
        logic       pcw, pcs, irw, asrc, mr, mw, m2r, rw;
        logic [1:0] aop;
        pcw = 1'b0; pcs = 1'b0; irw = 1'b0; asrc = 1'b0; aop = 2'b00;
        mr = 1'b0; mw = 1'b0; m2r = 1'b0; rw = 1'b0;
        if (ph == P_F) begin
            irw = 1'b1;
        end else if (ph == P_E) begin
            if (cls == C_R) begin
                aop = 2'b10;
            end else if (cls == C_I) begin
                asrc = 1'b1; aop = 2'b10;
            end else if (cls == C_LD || cls == C_ST) begin
                asrc = 1'b1;
            end else if (cls == C_BR) begin
                aop = 2'b01; pcw = 1'b1; pcs = zero;
            end
        end else if (ph == P_M) begin
            asrc = 1'b1;
            mr   = (cls == C_LD);
            mw   = (cls == C_ST);
            pcw  = (cls == C_ST) && ready;
        end else if (ph == P_W) begin
            rw = 1'b1; m2r = (cls == C_LD); pcw = 1'b1;
        end
        return {pcw, pcs, irw, asrc, aop, mr, mw, m2r, rw};
    endfunction

    // ------------------------------------------------------- compare process
    always @(negedge clk) begin
        if (exp_on) begin
            check("state", 32'(state), 32'(exp_state));
            check("strobes", 32'({pc_write, pc_src, ir_write, alu_src, alu_op,
                                  mem_read, mem_write, memto_reg, reg_write}), 32'(exp_strb));
            check("state_w4", 32'(state4), 32'(exp_state));
            check("strobes_w4", 32'({pc_write4, pc_src4, ir_write4, alu_src4, alu_op4,
                                     mem_read4, mem_write4, memto_reg4, reg_write4}), 32'(exp_strb));
            if (exp_flags) begin
                check("illegal", 32'(illegal), 32'(exp_ill));
                check("mem_timeout", 32'(mem_timeout), 32'(exp_to));
                check("inst_retired", inst_retired, exp_cnt);
                check("inst_retired_w4", 32'(inst_retired4), 32'(exp_cnt[3:0]));
            end
        end
    end

    // -------------------------------------------------------- driver tasks
    task automatic do_reset();
        // First cycle: reset is high but the registers have not yet been
        // cleared, so only state and strobes are defined.
        @(posedge clk); #1;
        reset = 1'b1; mem_ready = 1'b0;
        exp_on = 1'b1; exp_flags = 1'b0; exp_state = 3'd0; exp_strb = 10'd0;
        @(posedge clk); #1;
        m_cnt = 0; m_ill = 1'b0; m_to = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        exp_flags = 1'b1; exp_ill = 1'b0; exp_to = 1'b0; exp_cnt = 32'd0;
    endtask

    task automatic hold_fault(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            alu_zero  = 1'($urandom_range(0, 1));
            exp_on = 1'b1; exp_flags = 1'b1;
            exp_state = 3'(P_X); exp_strb = 10'd0;
            exp_ill = m_ill; exp_to = m_to; exp_cnt = m_cnt;
        end
    endtask

    // Plan one instruction, then play it cycle by cycle.
    //   n_low       : cycles memReady is held low in MEM
    //   abort_after : if > 0, stop after this many cycles (caller resets)
    //   lat         : number of cycles played
    task automatic run_instr(input logic [6:0] op, input logic zero, input int n_low,
                             input int abort_after, output int lat);
        logic [12:0] exp_q[$];   // {state, strobes} per cycle
        logic        rdy_q[$];
        int          cls;
        int          outcome;    // 0 retire, 1 illegal, 2 timeout, 3 aborted
        logic [12:0] e;
        cls = classify(op);
        outcome = 0;
        exp_q.push_back({3'(P_F), spec_outputs(P_F, cls, zero, 1'b0)}); rdy_q.push_back(1'b0);
        exp_q.push_back({3'(P_D), spec_outputs(P_D, cls, zero, 1'b0)}); rdy_q.push_back(1'b0);
        if (cls == C_BAD) begin
            outcome = 1;
        end else begin
            exp_q.push_back({3'(P_E), spec_outputs(P_E, cls, zero, 1'b0)}); rdy_q.push_back(1'b0);
            if (cls == C_LD || cls == C_ST) begin
                for (int k = 0; k < n_low && k < MEM_WAIT_MAX; k++) begin
                    exp_q.push_back({3'(P_M), spec_outputs(P_M, cls, zero, 1'b0)});
                    rdy_q.push_back(1'b0);
                end
                if (n_low >= MEM_WAIT_MAX) begin
                    outcome = 2;
                end else begin
                    exp_q.push_back({3'(P_M), spec_outputs(P_M, cls, zero, 1'b1)});
                    rdy_q.push_back(1'b1);
                    if (cls == C_LD) begin
                        exp_q.push_back({3'(P_W), spec_outputs(P_W, cls, zero, 1'b0)});
                        rdy_q.push_back(1'b0);
                    end
                end
            end else if (cls != C_BR) begin
                exp_q.push_back({3'(P_W), spec_outputs(P_W, cls, zero, 1'b0)});
                rdy_q.push_back(1'b0);
            end
        end
        if (abort_after > 0 && abort_after < exp_q.size()) begin
            while (exp_q.size() > abort_after) begin
                void'(exp_q.pop_back());
                void'(rdy_q.pop_back());
            end
            outcome = 3;
        end
        lat = exp_q.size();

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); #1;
            reset  = 1'b0;
            opcode = op;
            alu_zero  = (cls == C_BR) ? zero : 1'($urandom_range(0, 1));
            // memReady outside MEM is don't-care; scramble it.
            mem_ready = (int'(e[12:10]) == P_M) ? rdy_q.pop_front()
                                                : (1'($urandom_range(0, 1)) | 1'(0 * rdy_q.pop_front()));
            exp_on = 1'b1; exp_flags = 1'b1;
            exp_state = e[12:10]; exp_strb = e[9:0];
            exp_ill = m_ill; exp_to = m_to; exp_cnt = m_cnt;
        end

        if (outcome == 0) m_cnt++;
        else if (outcome == 1) m_ill = 1'b1;
        else if (outcome == 2) m_to = 1'b1;
    endtask

    // -------------------------------------------------------------- watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        int lat;

        do_reset();

        // Basic instruction mix
        run_instr(7'b0110011, 1'b0, 0, 0, lat); check("lat_r", lat, 4);
        check("model_cnt_after_r", m_cnt, 1);
        run_instr(7'b0010011, 1'b0, 0, 0, lat); check("lat_i", lat, 4);
        run_instr(7'b0000011, 1'b0, 2, 0, lat); check("lat_load_n2", lat, 7);
        run_instr(7'b1100011, 1'b1, 0, 0, lat); check("lat_branch_taken", lat, 3);
        run_instr(7'b1100011, 1'b0, 0, 0, lat); check("lat_branch_not_taken", lat, 3);
        run_instr(7'b0100011, 1'b0, 1, 0, lat); check("lat_store_n1", lat, 5);
        run_instr(7'b0000011, 1'b0, 14, 0, lat); check("lat_load_n14", lat, 19);
        check("model_cnt_after_mix", m_cnt, 7);

        // Store that never completes: 15 MEM cycles, then FAULT for 20 more
        run_instr(7'b0100011, 1'b0, 15, 0, lat); check("lat_store_timeout", lat, 18);
        hold_fault(20);
        check("model_timeout_flag", 32'(m_to), 1);
        check("model_cnt_after_timeout", m_cnt, 7);

        // Illegal opcode, then reset clears everything
        do_reset();
        run_instr(7'b1111111, 1'b0, 0, 0, lat); check("lat_illegal", lat, 2);
        hold_fault(3);
        check("model_illegal_flag", 32'(m_ill), 1);
        do_reset();

        // Counter wrap in the 4-bit copy: 15, 0, then 1
        for (int k = 0; k < 17; k++) begin
            run_instr(7'b0110011, 1'b0, 0, 0, lat);
        end
        check("model_cnt_17", m_cnt, 17);
        check("model_cnt_17_w4", m_cnt & 32'hF, 1);

        // Reset in the middle of a LOAD wait abandons the instruction
        run_instr(7'b0000011, 1'b0, 3, 5, lat); check("lat_load_aborted", lat, 5);
        do_reset();
        run_instr(7'b0100011, 1'b0, 0, 0, lat); check("lat_store_n0", lat, 4);
        run_instr(7'b0110011, 1'b0, 0, 0, lat);
        check("model_cnt_final", m_cnt, 2);

        @(posedge clk); #1;
        exp_on = 1'b0;
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Central sequencer for the RISC-V datapath. It converts the single-cycle datapath into a multi-cycle machine.
- It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the per-phase enables for the PC, instruction register, register file, ALU source/op and data memory.
- It waits on a data-memory ready handshake, with a timeout.
- It flags illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- MEM_WAIT_MAX, 15: number of consecutive MEM cycles with memReady low before a timeout fault; legal range 1..255.
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  7  opcode from the instruction register; stable from DECODE until the instruction retires
- aluZero  in  1  ALU zero flag (valid in EXECUTE)
- memReady  in  1  data-memory completion for the current access
- pcWrite  out  1  PC load enable
- pcSrc  out  1  0 = PC+4, 1 = branch target
- irWrite  out  1  instruction register load enable
- aluSrc  out  1  0 = readData2, 1 = immediate
- aluOp  out  2  00 add, 01 sub/compare, 10 funct-decoded
- memRead  out  1  data-memory read strobe
- memWrite  out  1  data-memory write strobe
- memtoReg  out  1  writeback source: 1 = memory, 0 = ALU
- regWrite  out  1  register file write enable
- state  out  3  current state encoding
- illegal  out  1  sticky illegal-opcode fault
- memTimeout  out  1  sticky memory-timeout fault
- instRetired  out  CNT_WIDTH  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7; codes 5 and 6 go to FAULT with illegal=1.
- Reset (synchronous, checked before any other update):
  - state=FETCH, instRetired=0, illegal=0, memTimeout=0, MEM wait counter=0.
  - While reset is high, every strobe output is 0 (pcWrite, irWrite, memRead, memWrite, regWrite, pcSrc, aluSrc, memtoReg), aluOp=00 and state reads 0.
  - Reset asserted in any state, including mid-MEM wait, abandons the instruction.
- Strobe outputs are combinational from state, opcode and aluZero. Any strobe not listed for a state is 0.
- Supported opcode classes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
- FETCH: irWrite=1. Next state DECODE.
- DECODE: no strobes. Next state EXEC if the opcode is supported; otherwise FAULT, and illegal is set on that edge.
- EXEC:
  - R: aluSrc=0, aluOp=10. Next WB.
  - I-ALU: aluSrc=1, aluOp=10. Next WB.
  - LOAD/STORE: aluSrc=1, aluOp=00. Next MEM; wait counter cleared on that edge.
  - BRANCH: aluSrc=0, aluOp=01, pcWrite=1, pcSrc=aluZero. The instruction retires. Next FETCH.
- MEM:
  - aluSrc=1, aluOp=00; memRead=1 for LOAD, memWrite=1 for STORE, held every cycle until exit.
  - memReady=1: LOAD goes to WB. STORE asserts pcWrite=1 (pcSrc=0), retires and goes to FETCH.
  - memReady=0 and counter < MEM_WAIT_MAX-1: counter increments, state stays MEM.
  - memReady=0 and counter == MEM_WAIT_MAX-1: go to FAULT, memTimeout set. MEM_WAIT_MAX=1 faults on the first cycle without ready.
  - memReady outside MEM is ignored.
- WB: regWrite=1, memtoReg=1 for LOAD and 0 otherwise, pcWrite=1, pcSrc=0. The instruction retires. Next FETCH.
- FAULT: all strobes 0; illegal and memTimeout hold their values. Only reset exits FAULT.
- Retire: instRetired increments by 1 on the edge leaving the retiring state and wraps to 0 from all-ones. The faulting instruction does not count.
- Latency in cycles, FETCH to next FETCH, where N = number of memReady-low cycles:
  - BRANCH: 3
  - R and I-ALU: 4
  - STORE: 4 + N
  - LOAD: 5 + N

Test Plan:
- R-type add (opcode 0110011) after reset release → state sequence 0,1,2,4,0; irWrite only in cycle 1; regWrite=1, memtoReg=0, pcWrite=1 only in WB; instRetired=1.
- LOAD (0000011) with memReady low for 2 cycles then high → memRead high for 3 MEM cycles, then WB with memtoReg=1, regWrite=1; total 7 cycles; instRetired increments once.
- BRANCH (1100011) twice, aluZero=1 then aluZero=0 → EXEC shows pcWrite=1 with pcSrc=1, then pcSrc=0; each instruction takes 3 cycles; regWrite never asserts.
- STORE with memReady held 0 and MEM_WAIT_MAX=15 → memWrite high for exactly 15 cycles, then state=7 and memTimeout=1; state stays 7 for 20 more cycles; instRetired unchanged.
- Opcode 1111111 → DECODE goes to FAULT, illegal=1, all strobes 0; synchronous reset pulse → state=0, illegal=0, instRetired=0.
- CNT_WIDTH=4: retire 17 R-type instructions → instRetired reads 15 then 0 then 1; reset asserted mid-MEM of a LOAD → next cycle state=0 with no memRead.
